window_3x3_gen: RTL and testbench

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

---
 rtl/window_3x3_gen.sv | 127 ++++++++++++
 tb/tb_window_3x3_gen.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/window_3x3_gen.sv
// window_3x3_gen: builds a sliding 3x3 window over a raster-scanned frame.
// Latency: window for an accepted pixel appears 1 cycle later (2 cycles with WINDOW_3X3_OUT_REG_EN).
// Backpressure: none; t=0 idle cycles freeze counters, window and line buffers.
//
// Optional feature macro: WINDOW_3X3_OUT_REG_EN adds one output register stage.
//
// Ports:
//   clk        - single clock, rising edge
//   rst        - synchronous active-high reset (wins over t)
//   t          - pixel strobe, in_data accepted when high
//   in_data    - raster-order pixel
//   out_data   - 3x3 window [row][col]; [0][*] oldest row, [*][0] oldest column
//   out_valid  - window is a complete interior window (accepted pixel r>=2, c>=2)
//   frame_done - pulses with out_valid for the last pixel of the frame
module window_3x3_gen #(
  parameter int unsigned ELEMENT_WIDTH = 32,
  parameter int unsigned IMG_WIDTH     = 64,
  parameter int unsigned IMG_HEIGHT    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               t,
  input  logic [ELEMENT_WIDTH-1:0]           in_data,
  output logic [2:0][2:0][ELEMENT_WIDTH-1:0] out_data,
  output logic                               out_valid,
  output logic                               frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  typedef logic [2:0][2:0][ELEMENT_WIDTH-1:0] win_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  win_t          win_q, win_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;

  // LB1 holds the previous row, LB2 the row before that; never reset.
  logic [ELEMENT_WIDTH-1:0] lb1_q [IMG_WIDTH];
  logic [ELEMENT_WIDTH-1:0] lb2_q [IMG_WIDTH];

  logic last_col, last_row;

  assign last_col = (col_q == CW'(IMG_WIDTH - 1));
  assign last_row = (row_q == RW'(IMG_HEIGHT - 1));

  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    win_d   = win_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (t) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
      // Shift left one column, new column enters on the right. Reads see
      // the line-buffer contents from before this cycle's write.
      for (int r = 0; r < 3; r++) begin
        win_d[r][0] = win_q[r][1];
        win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb2_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = in_data;
      // Requiring c>=2 keeps columns from the previous row out of any
      // window reported as valid.
      valid_d = (row_q >= RW'(2)) && (col_q >= CW'(2));
      done_d  = last_row && last_col;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      win_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && t) begin
      lb2_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_data;
    end
  end

`ifdef WINDOW_3X3_OUT_REG_EN
  win_t out_data_q;
  logic out_valid_q;
  logic frame_done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      out_data_q   <= win_q;
      out_valid_q  <= valid_q;
      frame_done_q <= done_q;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;
`else
  assign out_data   = win_q;
  assign out_valid  = valid_q;
  assign frame_done = done_q;
`endif

endmodule

// File: tb/tb_window_3x3_gen.sv
// tb_window_3x3_gen: scoreboard bench for window_3x3_gen on a 4x4 frame.
// Latency: expects windows 1 cycle after acceptance (2 with WINDOW_3X3_OUT_REG_EN).
// Backpressure: none; stimulus includes idle gaps and a mid-frame reset.
module tb_window_3x3_gen;

  localparam int EW  = 32;
  localparam int IW  = 4;
  localparam int IH  = 4;
`ifdef WINDOW_3X3_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef logic [2:0][2:0][EW-1:0] win_t;
  typedef struct {
    win_t w;
    logic done;
    int   cyc;
  } exp_t;

  logic          clk;
  logic          rst;
  logic          t;
  logic [EW-1:0] in_data;
  win_t          out_data;
  logic          out_valid;
  logic          frame_done;

  int   total;
  int   bad;
  int   cyc;
  int   vcount;
  exp_t sb[$];

  window_3x3_gen #(
    .ELEMENT_WIDTH(EW),
    .IMG_WIDTH(IW),
    .IMG_HEIGHT(IH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .t(t),
    .in_data(in_data),
    .out_data(out_data),
    .out_valid(out_valid),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [319:0] got, input logic [319:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitor: sample #1 after each rising edge.
  always @(posedge clk) begin
    exp_t e;
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      chk("missed_valid_cyc", 320'(cyc), 320'(e.cyc));
    end
    if (out_valid === 1'b1) begin
      vcount++;
      if (sb.size() == 0) begin
        chk("unexp_valid", 320'(out_valid), 320'(0));
      end else begin
        e = sb.pop_front();
        chk("valid_cyc", 320'(cyc), 320'(e.cyc));
        chk("window", 320'(out_data), 320'(e.w));
        chk("frame_done", 320'(frame_done), 320'(e.done));
      end
    end else begin
      chk("done_wo_valid", 320'(frame_done), 320'(0));
    end
  end

  task automatic drive(input logic tv, input logic [EW-1:0] d);
    @(negedge clk);
    t       = tv;
    in_data = d;
  endtask

  task automatic send_pix(input int r, input int c, input int base);
    exp_t e;
    drive(1'b1, EW'(base + 4 * r + c));
    if (r >= 2 && c >= 2) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          e.w[i][j] = EW'(base + 4 * (r - 2 + i) + (c - 2 + j));
      e.done = (r == IH - 1) && (c == IW - 1);
      // Accepted at edge cyc+1; visible at monitor cycle cyc+LAT.
      e.cyc  = cyc + LAT;
      sb.push_back(e);
    end
  endtask

  task automatic send_frame(input int base, input bit gaps);
    for (int r = 0; r < IH; r++)
      for (int c = 0; c < IW; c++) begin
        send_pix(r, c, base);
        if (gaps) begin
          drive(1'b0, $urandom);
          drive(1'b0, $urandom);
        end
      end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    total   = 0;
    bad     = 0;
    cyc     = 0;
    vcount  = 0;
    rst     = 1'b1;
    t       = 1'b0;
    in_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 320'(out_valid), 320'(0));
    chk("rst_done", 320'(frame_done), 320'(0));
    chk("rst_data", 320'(out_data), 320'(0));
    rst = 1'b0;

    // Two back-to-back frames, t held high.
    send_frame(0, 1'b0);
    send_frame(100, 1'b0);
    idle(4);

    // Same frame with two idle cycles after every pixel.
    send_frame(0, 1'b1);
    idle(4);

    // Six pixels, then reset with t high in the same cycle.
    for (int p = 0; p < 6; p++) send_pix(p / IW, p % IW, 0);
    @(negedge clk);
    rst     = 1'b1;
    t       = 1'b1;
    in_data = 99;
    @(negedge clk);
    chk("midrst_valid", 320'(out_valid), 320'(0));
    chk("midrst_data", 320'(out_data), 320'(0));
    rst = 1'b0;
    t   = 1'b0;
    send_frame(0, 1'b0);
    idle(5);

    chk("sb_empty", 320'(sb.size()), 320'(0));
    chk("valid_cnt", 320'(vcount), 320'(16));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
